// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I controller: opcodes, FSM states, mux encodings.
// Optional JAL support is enabled by defining MC_JAL_EN.
package riscv_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_IARITH = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_A     = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_B    = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
`ifdef MC_JAL_EN
    , S_JAL    = 4'd11
`endif
  } mc_state_t;

  // Datapath control bundle produced by the state decoder.
  typedef struct packed {
    logic        pc_write;
    logic        adr_src;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    result_src_t result_src;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    alu_op_t     alu_op;
    logic        instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state-to-control decode for the multicycle controller.
// The JAL state decode is present only when MC_JAL_EN is defined.
module mc_output_decode
  import riscv_pkg::*;
(
  input  mc_state_t state,
  input  logic      zero,
  input  logic      mem_ack,
  output ctrl_t     ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ack;
        ctrl.pc_write   = mem_ack;
      end
      // Branch/jump target lands in ALUOut while the opcode is decoded.
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.adr_src  = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.instr_done = mem_ack;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_JAL_EN
      // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: state register, next-state logic and reset output gating.
// Defining MC_JAL_EN adds the JAL instruction path.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                mem_ack,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                illegal_op,
  output logic                instr_done
);

  mc_state_t state;
  mc_state_t next_state;
  logic      op_illegal;
  ctrl_t     ctrl;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    op_illegal = 1'b0;
    case (state)
      S_IDLE:  next_state = S_FETCH;
      S_FETCH: if (mem_ack) next_state = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_IARITH:         next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BEQ;
`ifdef MC_JAL_EN
          OP_JAL:            next_state = S_JAL;
`endif
          default: begin
            next_state = S_FETCH;
            op_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_LOAD)       next_state = S_MEMREAD;
        else if (Opcode == OP_STORE) next_state = S_MEMWRITE;
        else                         next_state = S_FETCH;
      end
      S_MEMREAD:  if (mem_ack) next_state = S_MEMWB;
      S_MEMWRITE: if (mem_ack) next_state = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ: next_state = S_FETCH;
      S_EXECR, S_EXECI:        next_state = S_ALUWB;
`ifdef MC_JAL_EN
      S_JAL:                   next_state = S_ALUWB;
`endif
      default:                 next_state = S_IDLE;
    endcase
  end

  mc_output_decode u_decode (
    .state   (state),
    .zero    (Zero),
    .mem_ack (mem_ack),
    .ctrl    (ctrl)
  );

  // Reset kills every control immediately, including an in-flight memory write.
  assign PCWrite    = ~reset & ctrl.pc_write;
  assign AdrSrc     = ~reset & ctrl.adr_src;
  assign MemRead    = ~reset & ctrl.mem_read;
  assign MemWrite   = ~reset & ctrl.mem_write;
  assign IRWrite    = ~reset & ctrl.ir_write;
  assign RegWrite   = ~reset & ctrl.reg_write;
  assign ResultSrc  = reset ? 2'b00 : ctrl.result_src;
  assign ALUSrcA    = reset ? 2'b00 : ctrl.alu_src_a;
  assign ALUSrcB    = reset ? 2'b00 : ctrl.alu_src_b;
  assign ALUOp      = reset ? 2'b00 : ctrl.alu_op;
  assign illegal_op = ~reset & op_illegal;
  assign instr_done = ~reset & (ctrl.instr_done | op_illegal);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors are
// queued by the stimulus process and checked by a negedge monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = 7'b0;
  logic       Zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       illegal_op, instr_done;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ack(mem_ack),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_op(illegal_op), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemRead,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal_op,instr_done}
  logic [15:0] act;
  assign act = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op, instr_done};

  localparam logic [15:0] E_ZERO    = 16'h0000;
  localparam logic [15:0] E_FWAIT   = 16'h2220;
  localparam logic [15:0] E_FACK    = 16'hAA20;
  localparam logic [15:0] E_DEC     = 16'h0050;
  localparam logic [15:0] E_DEC_ILL = 16'h0053;
  localparam logic [15:0] E_MEMADR  = 16'h0090;
  localparam logic [15:0] E_MEMRD   = 16'h6000;
  localparam logic [15:0] E_MEMWB   = 16'h0501;
  localparam logic [15:0] E_MWWAIT  = 16'h5000;
  localparam logic [15:0] E_MWACK   = 16'h5001;
  localparam logic [15:0] E_EXECR   = 16'h0088;
  localparam logic [15:0] E_EXECI   = 16'h0098;
  localparam logic [15:0] E_ALUWB   = 16'h0401;
  localparam logic [15:0] E_BEQ_T   = 16'h8085;
  localparam logic [15:0] E_BEQ_NT  = 16'h0085;
  localparam logic [15:0] E_JAL     = 16'h8060;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          stim_done = 1'b0;

  // One cycle of stimulus plus the control vector expected during that cycle.
  task automatic step(input string nm, input logic rst, input logic [6:0] op,
                      input logic z, input logic ack, input logic [15:0] e);
    @(posedge clk);
    #1;
    reset   = rst;
    Opcode  = op;
    Zero    = z;
    mem_ack = ack;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset holds every output at zero
    step("reset0", 1'b1, OP_R, 1'b1, 1'b1, E_ZERO);
    step("reset1", 1'b1, OP_R, 1'b1, 1'b1, E_ZERO);
    step("idle",   1'b0, OP_R, 1'b0, 1'b1, E_ZERO);

    // add, zero-wait
    step("add_fetch",  1'b0, OP_R, 1'b0, 1'b1, E_FACK);
    step("add_decode", 1'b0, OP_R, 1'b1, 1'b0, E_DEC);
    step("add_execr",  1'b0, OP_R, 1'b1, 1'b0, E_EXECR);
    step("add_aluwb",  1'b0, OP_R, 1'b1, 1'b1, E_ALUWB);

    // lw with 3 wait cycles in FETCH and MEMREAD
    for (int i = 0; i < 3; i++) step("lw_fetch_wait", 1'b0, OP_LW, 1'b0, 1'b0, E_FWAIT);
    step("lw_fetch_ack", 1'b0, OP_LW, 1'b0, 1'b1, E_FACK);
    step("lw_decode",    1'b0, OP_LW, 1'b0, 1'b0, E_DEC);
    step("lw_memadr",    1'b0, OP_LW, 1'b0, 1'b1, E_MEMADR);
    for (int i = 0; i < 3; i++) step("lw_memrd_wait", 1'b0, OP_LW, 1'b0, 1'b0, E_MEMRD);
    step("lw_memrd_ack", 1'b0, OP_LW, 1'b0, 1'b1, E_MEMRD);
    step("lw_memwb",     1'b0, OP_LW, 1'b0, 1'b1, E_MEMWB);

    // beq taken, then not taken
    step("beq1_fetch",  1'b0, OP_BR, 1'b0, 1'b1, E_FACK);
    step("beq1_decode", 1'b0, OP_BR, 1'b0, 1'b1, E_DEC);
    step("beq1_taken",  1'b0, OP_BR, 1'b1, 1'b1, E_BEQ_T);
    step("beq2_fetch",  1'b0, OP_BR, 1'b1, 1'b1, E_FACK);
    step("beq2_decode", 1'b0, OP_BR, 1'b1, 1'b1, E_DEC);
    step("beq2_nt",     1'b0, OP_BR, 1'b0, 1'b1, E_BEQ_NT);

    // addi
    step("addi_fetch",  1'b0, OP_I, 1'b0, 1'b1, E_FACK);
    step("addi_decode", 1'b0, OP_I, 1'b0, 1'b1, E_DEC);
    step("addi_execi",  1'b0, OP_I, 1'b0, 1'b1, E_EXECI);
    step("addi_aluwb",  1'b0, OP_I, 1'b0, 1'b1, E_ALUWB);

    // unsupported opcode
    step("bad_fetch",  1'b0, OP_BAD, 1'b0, 1'b1, E_FACK);
    step("bad_decode", 1'b0, OP_BAD, 1'b0, 1'b1, E_DEC_ILL);

    // jal: legal only with the optional feature
    step("jal_fetch", 1'b0, OP_JAL, 1'b0, 1'b1, E_FACK);
`ifdef MC_JAL_EN
    step("jal_decode", 1'b0, OP_JAL, 1'b0, 1'b1, E_DEC);
    step("jal_jal",    1'b0, OP_JAL, 1'b0, 1'b1, E_JAL);
    step("jal_aluwb",  1'b0, OP_JAL, 1'b0, 1'b1, E_ALUWB);
`else
    step("jal_decode_ill", 1'b0, OP_JAL, 1'b0, 1'b1, E_DEC_ILL);
`endif

    // sw aborted by reset in its 2nd MEMWRITE wait cycle
    step("sw1_fetch",  1'b0, OP_SW, 1'b0, 1'b1, E_FACK);
    step("sw1_decode", 1'b0, OP_SW, 1'b0, 1'b1, E_DEC);
    step("sw1_memadr", 1'b0, OP_SW, 1'b0, 1'b1, E_MEMADR);
    step("sw1_mw_wait", 1'b0, OP_SW, 1'b0, 1'b0, E_MWWAIT);
    step("sw1_mw_reset", 1'b1, OP_SW, 1'b0, 1'b1, E_ZERO);
    step("sw1_idle",    1'b0, OP_SW, 1'b0, 1'b1, E_ZERO);

    // sw completing after one wait cycle
    step("sw2_fetch",   1'b0, OP_SW, 1'b0, 1'b1, E_FACK);
    step("sw2_decode",  1'b0, OP_SW, 1'b0, 1'b1, E_DEC);
    step("sw2_memadr",  1'b0, OP_SW, 1'b0, 1'b1, E_MEMADR);
    step("sw2_mw_wait", 1'b0, OP_SW, 1'b0, 1'b0, E_MWWAIT);
    step("sw2_mw_ack",  1'b0, OP_SW, 1'b0, 1'b1, E_MWACK);
    step("sw2_next_fetch", 1'b0, OP_R, 1'b0, 1'b0, E_FWAIT);

    stim_done = 1'b1;
    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
